// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - button input and debounced outputs bundled as one port
interface button_debouncer_if;
  logic btn_in;
  logic level;
  logic trigger;
  logic release_pulse;

  // Driver side: owns the raw button, observes the debounced result
  modport master (
    output btn_in,
    input  level,
    input  trigger,
    input  release_pulse
  );

  // Debouncer side: consumes the raw button, produces the debounced result
  modport slave (
    input  btn_in,
    output level,
    output trigger,
    output release_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser and four-state debounce FSM
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter bit          ACTIVE_HIGH   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  button_debouncer_if.slave bus
);

  // Counter only ever needs to reach STABLE_CYCLES-1, so ceil(log2) bits suffice
  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  // Polarity-corrected raw input: 1 always means "pressed" from here on
  logic btn_d;
  assign btn_d = ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;

  logic             s1_q;
  logic             s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             trigger_q;
  logic             release_q;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_d;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM: a change is accepted only after STABLE_CYCLES identical
  // synchronised samples; any differing sample drops back and restarts.
  // Pulses are one cycle wide because they default low every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      trigger_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (s2_q) begin
            state_q <= S_RISE;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_RISE: begin
          if (!s2_q) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= S_HIGH;
            level_q   <= 1'b1;
            trigger_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!s2_q) begin
            state_q <= S_FALL;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_FALL: begin
          if (s2_q) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= S_LOW;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from flops so the downstream edge-sensitive
  // counter never sees a combinational glitch
  assign bus.level         = level_q;
  assign bus.trigger       = trigger_q;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
module tb_button_debouncer;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debouncer_if bif();

  button_debouncer #(.STABLE_CYCLES(SC), .ACTIVE_HIGH(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  typedef struct {
    int cyc;
    bit rel;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // reference model state
  bit        m_level = 1'b0;
  bit [1:0]  m_pipe = 2'b00;
  bit        m_win[$];
  int        m_press = 0;

  // downstream 8-bit event counter driven by trigger, plus observation
  logic [7:0] cnt8 = 8'd0;
  int         rel_cnt = 0;
  int         last_trig = -1;
  int         last_rel = -1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the FSM sees the button two edges late; the level flips
  // once the last SC samples seen since reset all disagree with it.
  initial begin
    bit smp;
    bit all_diff;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_pipe  = 2'b00;
        m_win.delete();
        m_level = 1'b0;
      end else begin
        smp    = m_pipe[1];
        m_pipe = {m_pipe[0], bif.btn_in};
        m_win.push_back(smp);
        if (m_win.size() > SC) void'(m_win.pop_front());
        if (m_win.size() == SC) begin
          all_diff = 1'b1;
          foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
          if (all_diff) begin
            m_level = !m_level;
            exp_q.push_back('{cyc, !m_level});
            if (m_level) m_press++;
          end
        end
      end
    end
  end

  // Monitor: samples 1 time unit after each edge, pops expected events
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("level", bif.level, m_level);
      if (bif.trigger && bif.release_pulse) chk("pulse_overlap", 1, 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_pulse_cycle", cyc, e.cyc);
      end
      if (bif.trigger || bif.release_pulse) begin
        chk("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_kind", bif.release_pulse, e.rel);
        end
      end
      if (bif.trigger) begin
        cnt8 = cnt8 + 8'd1;
        last_trig = cyc;
      end
      if (bif.release_pulse) begin
        rel_cnt++;
        last_rel = cyc;
      end
    end
  end

  // Drive btn_in at a falling edge and hold it for n cycles
  task automatic hold(input logic v, input int n);
    bif.btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e_edge;
    int c0;
    int r0;
    logic v;
    bif.btn_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    // reset held, button toggling randomly
    repeat (12) hold(1'($urandom_range(0, 1)), 1);
    chk("reset_count", cnt8, 0);
    chk("reset_trigger", bif.trigger, 0);
    chk("reset_release", bif.release_pulse, 0);
    bif.btn_in = 1'b0;
    rst_n = 1'b1;
    hold(1'b0, 10);

    // clean press and release
    c0 = cnt8;
    e_edge = cyc + 1;
    hold(1'b1, 20);
    chk("press_latency", last_trig, e_edge + 5);
    chk("press_count", cnt8, c0 + 1);
    e_edge = cyc + 1;
    hold(1'b0, 20);
    chk("release_latency", last_rel, e_edge + 5);

    // bounce then hold
    c0 = cnt8;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b1, 1); hold(1'b0, 1);
    e_edge = cyc + 1;
    hold(1'b1, 20);
    chk("bounce_latency", last_trig, e_edge + 5);
    chk("bounce_count", cnt8, c0 + 1);
    hold(1'b0, 20);

    // short glitch
    c0 = cnt8;
    hold(1'b1, 3);
    hold(1'b0, 20);
    chk("glitch_count", cnt8, c0);

    // ten clean presses
    c0 = cnt8;
    r0 = rel_cnt;
    repeat (10) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    chk("ten_trigger", cnt8, (c0 + 10) % 256);
    chk("ten_release", rel_cnt, r0 + 10);

    // reset two cycles into the rise window, button held through release
    c0 = cnt8;
    hold(1'b1, 4);
    rst_n = 1'b0;
    hold(1'b1, 3);
    chk("midreset_no_pulse", cnt8, c0);
    rst_n = 1'b1;
    e_edge = cyc + 1;
    hold(1'b1, 20);
    chk("midreset_latency", last_trig, e_edge + 5);
    chk("midreset_count", cnt8, (c0 + 1) % 256);
    hold(1'b0, 20);

    // randomized segments with occasional resets
    repeat (60) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) begin
        rst_n = 1'b0;
        hold(v, 2);
        rst_n = 1'b1;
      end
      hold(v, $urandom_range(1, 9));
    end
    hold(1'b0, 20);

    chk("final_count", cnt8, m_press % 256);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule
